// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared fixed-point helpers for the frame accumulator datapath
// Purpose: frame state encoding, frame counter width and signed range limits per width.
// Ports: none (package).
package fxp_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Counter wide enough to hold 0..frame_len.
  function automatic int cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

  function automatic longint smax(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fxp_saturate.sv
// rtl/fxp_saturate.sv - combinational signed clamp from IN_W to OUT_W bits
// Purpose: clamp a signed value into the signed OUT_W range and flag when clamping occurred.
// Ports: din (signed IN_W), dout (signed OUT_W), ovf (1 = value was clamped). Requires IN_W >= OUT_W.
module fxp_saturate
  import fxp_pkg::*;
#(
  parameter int IN_W  = 13,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  // Output range limits expressed in the input width so the compare is exact.
  localparam logic signed [IN_W-1:0]  HI_IN  = IN_W'(smax(OUT_W));
  localparam logic signed [IN_W-1:0]  LO_IN  = IN_W'(smin(OUT_W));
  localparam logic signed [OUT_W-1:0] HI_OUT = OUT_W'(smax(OUT_W));
  localparam logic signed [OUT_W-1:0] LO_OUT = OUT_W'(smin(OUT_W));

  always_comb begin
    dout = din[OUT_W-1:0];
    ovf  = 1'b0;
    if (din > HI_IN) begin
      dout = HI_OUT;
      ovf  = 1'b1;
    end else if (din < LO_IN) begin
      dout = LO_OUT;
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/fxp_frame_accumulator.sv
// rtl/fxp_frame_accumulator.sv - saturating per-frame sum, rounded shift and narrowed result
// Purpose: sum FRAME_LEN accepted signed samples with saturation, scale by >>> SHIFT with
//   half-up rounding, clamp to OUT_W and hand one result per frame to the consumer.
// Ports: i_clk, i_reset_n (sync, active-low); i_valid/o_ready/i_data sample input;
//   i_clear aborts the frame in progress; o_valid/i_ready/o_data/o_sat frame result.
module fxp_frame_accumulator
  import fxp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int OUT_W     = 8,
  parameter int FRAME_LEN = 8,
  parameter int SHIFT     = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_sat
);

  localparam int                     CNT_W = cnt_w(FRAME_LEN);
  localparam logic [CNT_W-1:0]       LAST  = CNT_W'(FRAME_LEN - 1);
  // Half-LSB rounding term; zero when no shift is applied.
  localparam logic signed [ACC_W:0]  RND   =
    (SHIFT > 0) ? ((ACC_W+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]         count;
  logic                     sat_sticky, sticky_nxt;
  logic                     acc_ovf, out_ovf;
  logic                     accept, last;
  logic signed [ACC_W:0]    sum_w, rnd_w, scaled_w;
  logic signed [OUT_W-1:0]  res_nxt;

  assign accept = i_valid && o_ready;
  assign last   = (count == LAST);

  // One extra bit of headroom so the add can never wrap before the clamp.
  assign sum_w = {acc[ACC_W-1], acc} + {{(ACC_W+1-DATA_W){i_data[DATA_W-1]}}, i_data};

  fxp_saturate #(.IN_W(ACC_W+1), .OUT_W(ACC_W)) u_acc_sat (
    .din  (sum_w),
    .dout (acc_nxt),
    .ovf  (acc_ovf)
  );

  assign sticky_nxt = sat_sticky | acc_ovf;
  assign rnd_w      = {acc_nxt[ACC_W-1], acc_nxt} + RND;
  assign scaled_w   = rnd_w >>> SHIFT;

  fxp_saturate #(.IN_W(ACC_W+1), .OUT_W(OUT_W)) u_out_sat (
    .din  (scaled_w),
    .dout (res_nxt),
    .ovf  (out_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= ACCUM;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last) state_nxt = HOLD;
      HOLD:    if (i_ready)        state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    o_ready = (state == ACCUM) && !i_clear;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      acc        <= '0;
      count      <= '0;
      sat_sticky <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_sat      <= 1'b0;
    end else if (state == ACCUM) begin
      if (i_clear) begin
        acc        <= '0;
        count      <= '0;
        sat_sticky <= 1'b0;
      end else if (accept) begin
        if (last) begin
          acc        <= '0;
          count      <= '0;
          sat_sticky <= 1'b0;
          o_data     <= res_nxt;
          o_sat      <= sticky_nxt | out_ovf;
          o_valid    <= 1'b1;
        end else begin
          acc        <= acc_nxt;
          count      <= count + CNT_W'(1);
          sat_sticky <= sticky_nxt;
        end
      end
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fxp_frame_accumulator.sv
// tb/tb_fxp_frame_accumulator.sv - self-checking bench for fxp_frame_accumulator
module tb_fxp_frame_accumulator;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_valid, i_clear, i_ready;
  logic [7:0] i_data;

  logic              or0, or1, or2;
  logic              ov0, ov1, ov2;
  logic signed [7:0] od0, od1, od2;
  logic              os0, os1, os2;

  int checks = 0;
  int errors = 0;
  int frm[4];

  always #5 i_clk = ~i_clk;

  // Main configuration, a narrow accumulator and an unshifted variant, all on shared inputs.
  fxp_frame_accumulator #(.DATA_W(8), .ACC_W(12), .OUT_W(8), .FRAME_LEN(4), .SHIFT(2)) u_dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(or0), .i_data(i_data),
    .i_clear(i_clear), .o_valid(ov0), .i_ready(i_ready), .o_data(od0), .o_sat(os0));

  fxp_frame_accumulator #(.DATA_W(8), .ACC_W(9), .OUT_W(8), .FRAME_LEN(4), .SHIFT(2)) u_dut_narrow (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(or1), .i_data(i_data),
    .i_clear(i_clear), .o_valid(ov1), .i_ready(i_ready), .o_data(od1), .o_sat(os1));

  fxp_frame_accumulator #(.DATA_W(8), .ACC_W(12), .OUT_W(8), .FRAME_LEN(4), .SHIFT(0)) u_dut_noshift (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(or2), .i_data(i_data),
    .i_clear(i_clear), .o_valid(ov2), .i_ready(i_ready), .o_data(od2), .o_sat(os2));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: integer sum clamped after each sample, floor((sum + half) / 2^shift), clamp to 8 bits.
  function automatic void model(input int s[4], input int acc_w, input int shift,
                                output int res, output int sat);
    int acc = 0;
    int mx  = (1 << (acc_w - 1)) - 1;
    int mn  = -(1 << (acc_w - 1));
    int r;
    sat = 0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + s[i];
      if (acc > mx) begin acc = mx; sat = 1; end
      if (acc < mn) begin acc = mn; sat = 1; end
    end
    r = acc + ((shift > 0) ? (1 << (shift - 1)) : 0);
    r = r >>> shift;
    if (r > 127)  begin r = 127;  sat = 1; end
    if (r < -128) begin r = -128; sat = 1; end
    res = r;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic accept_sample(input int v);
    int n = 0;
    i_valid = 1'b1;
    i_data  = v[7:0];
    #1;
    while (!or0 && n < 50) begin
      step();
      n++;
    end
    if (!or0) check("ready_timeout", 0, 1);
    step();
    i_valid = 1'b0;
  endtask

  task automatic run_frame(input int s[4], input int hold_cycles);
    int e0, s0, e1, s1, e2, s2;
    logic [7:0] junk;
    model(s, 12, 2, e0, s0);
    model(s, 9,  2, e1, s1);
    model(s, 12, 0, e2, s2);
    i_ready = (hold_cycles == 0);
    for (int i = 0; i < 4; i++) begin
      accept_sample(s[i]);
      if (i < 3) check("early_valid", int'(ov0), 0);
    end
    check("valid_latency", int'(ov0), 1);
    check("data_main", int'(od0), e0);
    check("sat_main", int'(os0), s0);
    check("data_narrow", int'(od1), e1);
    check("sat_narrow", int'(os1), s1);
    check("data_noshift", int'(od2), e2);
    check("sat_noshift", int'(os2), s2);
    for (int k = 0; k < hold_cycles; k++) begin
      junk    = 8'($urandom);
      i_valid = 1'b1;
      i_data  = junk;
      step();
      check("hold_ready", int'(or0), 0);
      check("hold_valid", int'(ov0), 1);
      check("hold_data", int'(od0), e0);
      check("hold_sat", int'(os0), s0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    check("release_valid", int'(ov0), 0);
    check("release_ready", int'(or0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_clear   = 1'b0;
    i_ready   = 1'b1;
    i_data    = '0;
    step();
    step();
    check("reset_valid", int'(ov0), 0);
    check("reset_data", int'(od0), 0);
    check("reset_sat", int'(os0), 0);
    check("reset_ready", int'(or0), 1);
    i_reset_n = 1'b1;
    step();

    frm = '{16, 32, 48, 64};   run_frame(frm, 0);
    frm = '{1, 1, 0, 0};       run_frame(frm, 0);
    frm = '{-1, -1, 0, 0};     run_frame(frm, 0);
    frm = '{-3, 0, 0, 0};      run_frame(frm, 0);
    frm = '{127, 127, 127, 127}; run_frame(frm, 0);
    frm = '{-128, -128, -128, -128}; run_frame(frm, 1);
    frm = '{16, 32, 48, 64};   run_frame(frm, 5);
    frm = '{3, -7, 100, -50};  run_frame(frm, 0);

    // Abort a partial frame; the sample presented alongside the clear must be dropped.
    accept_sample(127);
    accept_sample(127);
    i_valid = 1'b1;
    i_data  = 8'd99;
    i_clear = 1'b1;
    #1;
    check("clear_ready", int'(or0), 0);
    step();
    i_clear = 1'b0;
    i_valid = 1'b0;
    frm = '{4, 4, 4, 4};       run_frame(frm, 0);

    // Reset while a result is pending in HOLD.
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) accept_sample(5);
    check("pre_reset_valid", int'(ov0), 1);
    i_reset_n = 1'b0;
    step();
    check("hold_reset_valid", int'(ov0), 0);
    check("hold_reset_data", int'(od0), 0);
    check("hold_reset_sat", int'(os0), 0);
    i_reset_n = 1'b1;
    i_ready   = 1'b1;
    frm = '{8, 8, 8, 8};       run_frame(frm, 0);

    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 4; i++) begin
        rb     = 8'($urandom);
        frm[i] = int'($signed(rb));
      end
      if (f % 3 == 0) frm[$urandom_range(0, 3)] = ($urandom_range(0, 1) != 0) ? 127 : -128;
      run_frame(frm, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
